// File: rtl/anim_rate_ctrl.sv
// anim_rate_ctrl: frame-synchronous animation rate controller.
//
// Ramps step_size one unit at a time toward the requested speed, turns frame strobes into a
// registered one-cycle anim_tick, and supports pause/resume plus single-frame stepping while
// paused. Pattern cores advance only on anim_tick and read step_size in that same cycle.
//
// Optional feature: define SPEED_SLOWMO_EN to make speed==0 select slow-motion, where a tick
// is issued on every SLOW_DIV-th running frame. Without it, speed==0 behaves like speed 1.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous reset, active-low
//   vsync_rising in   one-cycle frame strobe
//   speed        in   requested speed (SPEED_W bits)
//   pause        in   enter paused (wins over resume)
//   resume       in   leave paused
//   step_once    in   while paused, arm one single-frame advance
//   paused       out  1 while in the paused state
//   step_size    out  current step size, always 1..MAX_SPEED
//   anim_tick    out  one-cycle advance pulse, 1 clk after vsync_rising
//   frame_count  out  number of anim_ticks issued, wraps at FRAME_W bits
module anim_rate_ctrl #(
  parameter int unsigned SPEED_W     = 3,
  parameter int unsigned MAX_SPEED   = 6,
  parameter int unsigned RAMP_FRAMES = 4,
  parameter int unsigned FRAME_W     = 8
`ifdef SPEED_SLOWMO_EN
  ,
  parameter int unsigned SLOW_DIV    = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_rising,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               resume,
  input  logic               step_once,
  output logic               paused,
  output logic [SPEED_W-1:0] step_size,
  output logic               anim_tick,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned RcW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  typedef enum logic [0:0] {StRun, StPaused} state_e;

  state_e             state_q, state_d;
  logic               armed_q;
  logic [RcW-1:0]     ramp_cnt_q;
  logic [SPEED_W-1:0] target;
  logic               run_frame, step_frame, tick_d, ramp_wrap;

  // Out-of-range requests (including 0) fall back to the slowest speed.
  always_comb begin
    target = SPEED_W'(1);
    if (speed != '0 && speed <= SPEED_W'(MAX_SPEED)) target = speed;
  end

  always_comb begin
    state_d = state_q;
    if (pause)       state_d = StPaused;
    else if (resume) state_d = StRun;
  end

  // The frame decision looks at next state so a same-cycle pause/resume takes effect at once.
  assign run_frame  = vsync_rising && (state_d == StRun);
  assign step_frame = vsync_rising && (state_d == StPaused) && armed_q;
  assign ramp_wrap  = (ramp_cnt_q == RcW'(RAMP_FRAMES - 1));

`ifdef SPEED_SLOWMO_EN
  localparam int unsigned ScW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  logic [ScW-1:0] slow_cnt_q;
  logic           slow_sel, slow_hit;

  assign slow_sel = (speed == '0);
  assign slow_hit = (slow_cnt_q == ScW'(SLOW_DIV - 1));
  assign tick_d   = step_frame || (run_frame && (!slow_sel || slow_hit));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slow_cnt_q <= '0;
    end else if (!slow_sel) begin
      slow_cnt_q <= '0;
    end else if (run_frame) begin
      slow_cnt_q <= slow_hit ? '0 : slow_cnt_q + ScW'(1);
    end
  end
`else
  assign tick_d = run_frame || step_frame;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      paused      <= 1'b0;
      step_size   <= SPEED_W'(1);
      anim_tick   <= 1'b0;
      frame_count <= '0;
      armed_q     <= 1'b0;
      ramp_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      paused    <= (state_d == StPaused);
      anim_tick <= tick_d;
      if (tick_d) frame_count <= frame_count + FRAME_W'(1);

      // A new step request coinciding with a consumed one re-arms for the next frame.
      if (!pause && resume) begin
        armed_q <= 1'b0;
      end else if (step_once && state_q == StPaused && state_d == StPaused) begin
        armed_q <= 1'b1;
      end else if (step_frame) begin
        armed_q <= 1'b0;
      end

      if (run_frame) begin
        if (ramp_wrap) begin
          ramp_cnt_q <= '0;
          if (step_size < target)      step_size <= step_size + SPEED_W'(1);
          else if (step_size > target) step_size <= step_size - SPEED_W'(1);
        end else begin
          ramp_cnt_q <= ramp_cnt_q + RcW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_anim_rate_ctrl.sv
module tb_anim_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync_rising;
  logic [2:0] speed;
  logic       pause;
  logic       resume;
  logic       step_once;
  logic       paused;
  logic [2:0] step_size;
  logic       anim_tick;
  logic [1:0] frame_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  anim_rate_ctrl #(
    .SPEED_W    (3),
    .MAX_SPEED  (6),
    .RAMP_FRAMES(2),
    .FRAME_W    (2)
`ifdef SPEED_SLOWMO_EN
    ,
    .SLOW_DIV   (4)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_rising(vsync_rising),
    .speed       (speed),
    .pause       (pause),
    .resume      (resume),
    .step_once   (step_once),
    .paused      (paused),
    .step_size   (step_size),
    .anim_tick   (anim_tick),
    .frame_count (frame_count)
  );

  // One frame strobe; returns tick/step in the cycle after the strobe and tick one cycle later.
  task automatic frame(output logic t, output logic [2:0] s, output logic t2);
    @(negedge clk) vsync_rising = 1'b1;
    @(negedge clk) vsync_rising = 1'b0;
    t = anim_tick;
    s = step_size;
    @(negedge clk);
    t2 = anim_tick;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vsync_rising = 1'b0; speed = 3'd1;
    pause = 1'b0; resume = 1'b0; step_once = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Disturb state first so reset has something to clear.
    rst_n = 1'b1; speed = 3'd1; pause = 1'b1; resume = 1'b0; step_once = 1'b0; vsync_rising = 1'b0;
    @(negedge clk) pause = 1'b0;
    do_reset();
    vectors++;
    if (paused !== 1'b0) begin
      miscompares++; $display("FAIL reset_paused: got %b expected 0", paused);
    end
    vectors++;
    if (step_size !== 3'd1) begin
      miscompares++; $display("FAIL reset_step: got %0d expected 1", step_size);
    end
    vectors++;
    if (anim_tick !== 1'b0) begin
      miscompares++; $display("FAIL reset_tick: got %b expected 0", anim_tick);
    end
    vectors++;
    if (frame_count !== 2'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d expected 0", frame_count);
    end
  endtask

  task automatic test_ramp();
    logic [2:0] exp_s [8];
    logic       t, t2;
    logic [2:0] s;
    exp_s = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
    do_reset();
    speed = 3'd4;
    for (int i = 0; i < 8; i++) begin
      frame(t, s, t2);
      vectors++;
      if (t !== 1'b1) begin
        miscompares++; $display("FAIL ramp_tick[%0d]: got %b expected 1", i, t);
      end
      vectors++;
      if (s !== exp_s[i]) begin
        miscompares++; $display("FAIL ramp_step[%0d]: got %0d expected %0d", i, s, exp_s[i]);
      end
      vectors++;
      if (t2 !== 1'b0) begin
        miscompares++; $display("FAIL ramp_pulse[%0d]: got %b expected 0", i, t2);
      end
    end
    vectors++;
    if (frame_count !== 2'd0) begin
      miscompares++; $display("FAIL ramp_count: got %0d expected 0", frame_count);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] exp_s [6];
    logic       t, t2;
    logic [2:0] s;
    exp_s = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1};
    do_reset();
    speed = 3'd3;
    for (int i = 0; i < 4; i++) frame(t, s, t2);
    vectors++;
    if (s !== 3'd3) begin
      miscompares++; $display("FAIL inv_preload: got %0d expected 3", s);
    end
    speed = 3'd7;
    for (int i = 0; i < 6; i++) begin
      frame(t, s, t2);
      vectors++;
      if (s !== exp_s[i]) begin
        miscompares++; $display("FAIL inv_step[%0d]: got %0d expected %0d", i, s, exp_s[i]);
      end
    end
    // Reset in the middle of a ramp.
    speed = 3'd4;
    frame(t, s, t2);
    frame(t, s, t2);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    vectors++;
    if (step_size !== 3'd1 || frame_count !== 2'd0) begin
      miscompares++;
      $display("FAIL midramp_reset: got step %0d count %0d expected step 1 count 0",
               step_size, frame_count);
    end
  endtask

  task automatic test_pause_step();
    logic       t, t2;
    logic [2:0] s;
    do_reset();
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
    vectors++;
    if (paused !== 1'b1) begin
      miscompares++; $display("FAIL pause_enter: got %b expected 1", paused);
    end
    for (int i = 0; i < 3; i++) begin
      frame(t, s, t2);
      vectors++;
      if (t !== 1'b0) begin
        miscompares++; $display("FAIL paused_tick[%0d]: got %b expected 0", i, t);
      end
    end
    @(negedge clk) step_once = 1'b1;
    @(negedge clk) step_once = 1'b1;
    @(negedge clk) step_once = 1'b0;
    frame(t, s, t2);
    vectors++;
    if (t !== 1'b1) begin
      miscompares++; $display("FAIL step_tick: got %b expected 1", t);
    end
    frame(t, s, t2);
    vectors++;
    if (t !== 1'b0) begin
      miscompares++; $display("FAIL step_once_only: got %b expected 0", t);
    end
    vectors++;
    if (paused !== 1'b1) begin
      miscompares++; $display("FAIL step_paused: got %b expected 1", paused);
    end
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    vectors++;
    if (paused !== 1'b0) begin
      miscompares++; $display("FAIL resume: got %b expected 0", paused);
    end
    for (int i = 0; i < 2; i++) begin
      frame(t, s, t2);
      vectors++;
      if (t !== 1'b1) begin
        miscompares++; $display("FAIL resumed_tick[%0d]: got %b expected 1", i, t);
      end
    end
  endtask

  task automatic test_collisions();
    do_reset();
    @(negedge clk) begin pause = 1'b1; resume = 1'b1; end
    @(negedge clk) begin pause = 1'b0; resume = 1'b0; end
    vectors++;
    if (paused !== 1'b1) begin
      miscompares++; $display("FAIL pause_beats_resume: got %b expected 1", paused);
    end
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    @(negedge clk) begin pause = 1'b1; vsync_rising = 1'b1; end
    @(negedge clk) begin pause = 1'b0; vsync_rising = 1'b0; end
    vectors++;
    if (anim_tick !== 1'b0 || paused !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_with_vsync: got tick %b paused %b expected tick 0 paused 1",
               anim_tick, paused);
    end
    @(negedge clk) begin resume = 1'b1; vsync_rising = 1'b1; end
    @(negedge clk) begin resume = 1'b0; vsync_rising = 1'b0; end
    vectors++;
    if (anim_tick !== 1'b1 || paused !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_with_vsync: got tick %b paused %b expected tick 1 paused 0",
               anim_tick, paused);
    end
    @(negedge clk);
    vectors++;
    if (anim_tick !== 1'b0) begin
      miscompares++; $display("FAIL resume_pulse: got %b expected 0", anim_tick);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_c [5];
    logic       t, t2;
    logic [2:0] s;
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frame(t, s, t2);
      vectors++;
      if (frame_count !== exp_c[i]) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, frame_count, exp_c[i]);
      end
    end
  endtask

  task automatic test_slowmo();
    logic       t, t2;
    logic [2:0] s;
    int         ticks;
    int         exp_ticks;
`ifdef SPEED_SLOWMO_EN
    exp_ticks = 2;
`else
    exp_ticks = 8;
`endif
    ticks = 0;
    do_reset();
    speed = 3'd0;
    for (int i = 0; i < 8; i++) begin
      frame(t, s, t2);
      if (t === 1'b1) ticks++;
    end
    vectors++;
    if (ticks !== exp_ticks) begin
      miscompares++; $display("FAIL speed0_ticks: got %0d expected %0d", ticks, exp_ticks);
    end
    vectors++;
    if (step_size !== 3'd1) begin
      miscompares++; $display("FAIL speed0_step: got %0d expected 1", step_size);
    end
  endtask

  initial begin
    rst_n = 1'b0; vsync_rising = 1'b0; speed = 3'd1;
    pause = 1'b0; resume = 1'b0; step_once = 1'b0;
    test_reset();
    test_ramp();
    test_invalid();
    test_pause_step();
    test_collisions();
    test_wrap();
    test_slowmo();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
